// File: rtl/id_ex_stage_if.sv
// One pipeline slot of decoded-instruction state; ID drives it into the
// stage, and the stage drives the registered copy out to EX.
interface id_ex_stage_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic [12:0]       ctrl;
  logic [3:0]        aluop;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] pc4;

  modport master (
    output valid, ctrl, aluop, rs, rt, rd, rdata1, rdata2, imm, pc4
  );

  modport slave (
    input  valid, ctrl, aluop, rs, rt, rd, rdata1, rdata2, imm, pc4
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// memory-stage freeze and saturating bubble/flush performance counters.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  id_ex_stage_if.slave      id,
  input  logic              flush,
  input  logic              mem_stall,
  id_ex_stage_if.master     ex,
  output logic              stall_if_id,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Control bundle bit positions (Controller ordering, MSB = RegDst)
  localparam int unsigned C_BRANCH   = 11;
  localparam int unsigned C_MEMREAD  = 10;
  localparam int unsigned C_MEMWRITE = 9;
  localparam int unsigned C_ALUSRC   = 7;
  localparam int unsigned C_REGWRITE = 6;
  localparam int unsigned C_BNE      = 0;

  logic              r_valid;
  logic [12:0]       r_ctrl;
  logic [3:0]        r_aluop;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc4;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_reads_rt;
  logic w_ex_load;
  logic w_load_use;
  logic w_bubble;

  always_comb begin
    w_reads_rt = !id.ctrl[C_ALUSRC] | id.ctrl[C_MEMWRITE] |
                 id.ctrl[C_BRANCH]  | id.ctrl[C_BNE];
    w_ex_load  = r_valid & r_ctrl[C_MEMREAD] & r_ctrl[C_REGWRITE] &
                 (r_rt != '0);
    w_load_use = w_ex_load & id.valid &
                 ((id.rs == r_rt) | (w_reads_rt & (id.rt == r_rt)));
    w_bubble   = flush | w_load_use;
    // A flush squashes the dependent instruction, so it must not stall IF/ID
    stall_if_id = mem_stall | (w_load_use & !flush);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_aluop      <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_rdata1     <= '0;
      r_rdata2     <= '0;
      r_imm        <= '0;
      r_pc4        <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else if (!mem_stall) begin
      if (w_bubble) begin
        r_valid  <= 1'b0;
        r_ctrl   <= '0;
        r_aluop  <= '0;
        r_rs     <= '0;
        r_rt     <= '0;
        r_rd     <= '0;
        r_rdata1 <= '0;
        r_rdata2 <= '0;
        r_imm    <= '0;
        r_pc4    <= '0;
      end else begin
        r_valid  <= id.valid;
        r_ctrl   <= id.ctrl;
        r_aluop  <= id.aluop;
        r_rs     <= id.rs;
        r_rt     <= id.rt;
        r_rd     <= id.rd;
        r_rdata1 <= id.rdata1;
        r_rdata2 <= id.rdata2;
        r_imm    <= id.imm;
        r_pc4    <= id.pc4;
      end

      if (flush) begin
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else if (w_load_use) begin
        if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign ex.valid    = r_valid;
  assign ex.ctrl     = r_ctrl;
  assign ex.aluop    = r_aluop;
  assign ex.rs       = r_rs;
  assign ex.rt       = r_rt;
  assign ex.rd       = r_rd;
  assign ex.rdata1   = r_rdata1;
  assign ex.rdata2   = r_rdata2;
  assign ex.imm      = r_imm;
  assign ex.pc4      = r_pc4;
  assign bubble_cnt  = r_bubble_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the five-stage MIPS pipeline, directly downstream of the Controller. It captures the decoded control bundle, register operands, immediate and PC+4 from ID, and presents them to EX one cycle later. It also owns load-use hazard detection (bubble insertion plus an IF/ID stall request), branch/jump flush, and whole-pipe freeze from the memory stage. Saturating bubble and flush counters support performance measurement.

## Interface
- DATA_W, 32, datapath width
- CNT_W, 16, width of each performance counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  13  Controller outputs, bit order [12:0] = RegDst, Branch, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite, Lui, jump, link, R31Write, RegtoPc, bne
- id_aluop  in  4  Controller ALUOp
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- id_rdata1, id_rdata2  in  DATA_W  register file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_pc4  in  DATA_W  PC+4 of the ID instruction
- flush  in  1  taken branch/jump resolved; squash the ID instruction
- mem_stall  in  1  downstream busy; freeze the pipe
- ex_valid  out  1  EX holds a real instruction
- ex_ctrl  out  13; ex_aluop  out  4; ex_rs, ex_rt, ex_rd  out  5; ex_rdata1, ex_rdata2, ex_imm, ex_pc4  out  DATA_W  registered copies
- stall_if_id  out  1  hold PC and IF/ID this cycle (combinational)
- bubble_cnt  out  CNT_W  load-use bubbles inserted
- flush_cnt  out  CNT_W  flush cycles applied

## Operation
- **Reset.** While rst=0, every registered output and both counters are 0. This takes effect immediately, with no clock edge needed.
- **Reads rt.** An ID instruction reads rt when `!id_ctrl.ALUSrc | id_ctrl.MemWrite | id_ctrl.Branch | id_ctrl.bne`.
- **load_use.** Asserted when all of the following hold:
  - ex_valid, ex_ctrl.MemRead and ex_ctrl.RegWrite
  - ex_rt != 0
  - id_valid
  - id_rs == ex_rt, or (reads rt and id_rt == ex_rt)
- **Actions, evaluated each edge in strict priority:**
  1. mem_stall=1: hold all ex_* registers; counters unchanged; flush and load_use ignored. The flush source must hold flush until mem_stall drops.
  2. flush=1: load a bubble; flush_cnt += 1.
  3. load_use=1: load a bubble; bubble_cnt += 1.
  4. Otherwise: ex_* <= id_*, and ex_valid <= id_valid.
- **Bubble.** All ex_* fields are 0, including ex_valid, ex_ctrl and ex_aluop.
- **stall_if_id.** Equals mem_stall | (load_use & !flush). flush forces the load-use term to 0.
- **Counters.** Each saturates at 2^CNT_W − 1 and never wraps.
- **No forwarding.** Forwarding is not done here; ex_rs and ex_rt are exported for the EX forwarding unit.

## Timing
- **Latency.** One cycle, ID to EX.
- **load_use and stall_if_id.** Both are combinational from registered ex_* state plus current id_* inputs, and are valid within the same cycle.
- **Load-use duration.** A load-use stall lasts exactly one cycle, because the bubble clears the EX load. The dependent instruction enters EX one cycle after the bubble.
- **Back-to-back loads.** A load followed by a dependent load stalls once per dependency.
- **mem_stall during load_use.** The stall persists. The bubble is inserted on the first edge with mem_stall=0, provided load_use still holds.
- **Reset mid-operation.** Any in-flight instruction is discarded. The first post-reset edge loads id_* normally.

## Test plan
- **Reset.** Hold id_valid=1 with add data, then assert rst=0 mid-cycle → all ex_* outputs, bubble_cnt and flush_cnt read 0 before the next edge.
- **Pass-through.** ID add with ctrl=13'h1040 (RegDst, RegWrite), aluop 0, rs=1, rt=2, rd=3, rdata1=5, rdata2=7 → after one edge: ex_valid=1, ex_ctrl=13'h1040, fields match, stall_if_id=0.
- **Load-use.** EX holds lw (ctrl MemRead|RegWrite|ALUSrc|MemToReg, rt=5), ID holds add with rs=5 → stall_if_id=1 that cycle; next edge gives a bubble with ex_ctrl=0 and bubble_cnt=1; the following edge puts the add in EX with stall_if_id=0.
- **No false stall.**
  - lw with rt=0 followed by add using $0 → no stall.
  - lw rt=5 followed by addi rs=4, rt=5 → no stall.
  - lw rt=5 followed by sw rt=5 → stall.
- **Flush priority.** flush=1 in the same cycle as load_use conditions → bubble, flush_cnt=1, bubble_cnt=0, stall_if_id=0.
- **Freeze and saturation.** mem_stall=1 for 3 cycles → ex_* unchanged, stall_if_id=1, counters unchanged. With CNT_W=2, apply 5 flushes → flush_cnt=3.
